// File: rtl/keypad_scanner_p.sv
`default_nettype none
// =============================================================================
// Module   : keypad_scanner_p
// Function : Matrix keypad scanner with debounce, ghost rejection and
//            optional typematic repeat.
// Revision : 1.0
// =============================================================================
module keypad_scanner_p #(
  parameter int NROWS           = 4,
  parameter int NCOLS           = 4,
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_EN       = 0,
  parameter int HOLD_DELAY      = 64,
  parameter int REPEAT_PERIOD   = 16,
  localparam int KW             = $clog2(NROWS * NCOLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NROWS-1:0] row_d,
  output logic [NCOLS-1:0] col_q,
  output logic [KW-1:0]    key_code,
  output logic             key_valid,
  output logic             key_repeat,
  output logic             key_held,
  output logic             key_release,
  output logic             multi_key
);

  localparam int RW   = $clog2(NROWS);
  localparam int CW   = $clog2(NCOLS);
  localparam int DW   = $clog2(SCAN_DIV);
  localparam int BW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int RPW  = $clog2(RMAX + 1);

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  logic [NROWS-1:0] sync_q, row_s_q;
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    col_idx_q, col_idx_d;
  logic [NCOLS-1:0] col_oh_q, col_oh_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [BW-1:0]    deb_q, deb_d;
  logic [RW-1:0]    cand_row_q, cand_row_d;
  logic [CW-1:0]    cand_col_q, cand_col_d;
  logic [RPW-1:0]   rep_q, rep_d;
  logic             rep_first_q, rep_first_d;
  logic [KW-1:0]    key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_repeat_q, key_repeat_d;
  logic             key_held_q, key_held_d;
  logic             key_release_q, key_release_d;
  logic             multi_key_q, multi_key_d;

  logic [CW-1:0]    col_next, cand_next;
  logic [RW-1:0]    row_enc;
  logic [NROWS-1:0] cand_oh;
  logic             rows_zero, rows_one, cand_bit;
  logic [RPW-1:0]   rep_inc, rep_thr;

  always_comb begin
    state_d       = state_q;
    col_idx_d     = col_idx_q;
    dwell_d       = dwell_q;
    deb_d         = deb_q;
    cand_row_d    = cand_row_q;
    cand_col_d    = cand_col_q;
    rep_d         = rep_q;
    rep_first_d   = rep_first_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_repeat_d  = 1'b0;
    key_held_d    = key_held_q;
    key_release_d = 1'b0;
    multi_key_d   = 1'b0;

    col_next  = (col_idx_q == CW'(NCOLS - 1)) ? '0 : col_idx_q + 1'b1;
    cand_next = (cand_col_q == CW'(NCOLS - 1)) ? '0 : cand_col_q + 1'b1;
    rows_zero = (row_s_q == '0);
    rows_one  = !rows_zero && ((row_s_q & (row_s_q - 1'b1)) == '0);
    cand_oh   = {{(NROWS-1){1'b0}}, 1'b1} << cand_row_q;
    cand_bit  = row_s_q[cand_row_q];
    rep_inc   = rep_q + 1'b1;
    rep_thr   = rep_first_q ? RPW'(HOLD_DELAY) : RPW'(REPEAT_PERIOD);

    row_enc = '0;
    for (int r = 0; r < NROWS; r++) begin
      if (row_s_q[r]) row_enc = RW'(r);
    end

    case (state_q)
      S_SCAN: begin
        if (dwell_q == DW'(SCAN_DIV - 1)) begin
          dwell_d = '0;
          if (rows_one) begin
            cand_row_d = row_enc;
            cand_col_d = col_idx_q;
            deb_d      = '0;
            state_d    = S_DEBOUNCE;
          end else begin
            col_idx_d   = col_next;
            multi_key_d = !rows_zero;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end

      S_DEBOUNCE: begin
        if (row_s_q != cand_oh) begin
          state_d   = S_SCAN;
          col_idx_d = cand_next;
          dwell_d   = '0;
        end else if (deb_q == BW'(DEBOUNCE_CYCLES - 1)) begin
          state_d     = S_HELD;
          deb_d       = '0;
          key_code_d  = KW'(cand_row_q) * KW'(NCOLS) + KW'(cand_col_q);
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          rep_d       = '0;
          rep_first_d = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end

      // Leaving HELD takes priority, so a repeat due on that edge is dropped.
      S_HELD: begin
        if (!cand_bit) begin
          state_d = S_RELEASE;
          deb_d   = '0;
        end else if (REPEAT_EN != 0) begin
          if (rep_inc == rep_thr) begin
            key_valid_d  = 1'b1;
            key_repeat_d = 1'b1;
            rep_d        = '0;
            rep_first_d  = 1'b0;
          end else begin
            rep_d = rep_inc;
          end
        end
      end

      S_RELEASE: begin
        if (cand_bit) begin
          state_d = S_HELD;
          deb_d   = '0;
        end else if (deb_q == BW'(DEBOUNCE_CYCLES - 1)) begin
          state_d       = S_SCAN;
          deb_d         = '0;
          key_held_d    = 1'b0;
          key_release_d = 1'b1;
          col_idx_d     = cand_next;
          dwell_d       = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end

      default: state_d = S_SCAN;
    endcase

    col_oh_d = {{(NCOLS-1){1'b0}}, 1'b1} << col_idx_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q        <= '0;
      row_s_q       <= '0;
      state_q       <= S_SCAN;
      col_idx_q     <= '0;
      col_oh_q      <= {{(NCOLS-1){1'b0}}, 1'b1};
      dwell_q       <= '0;
      deb_q         <= '0;
      cand_row_q    <= '0;
      cand_col_q    <= '0;
      rep_q         <= '0;
      rep_first_q   <= 1'b0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_repeat_q  <= 1'b0;
      key_held_q    <= 1'b0;
      key_release_q <= 1'b0;
      multi_key_q   <= 1'b0;
    end else begin
      sync_q        <= row_d;
      row_s_q       <= sync_q;
      state_q       <= state_d;
      col_idx_q     <= col_idx_d;
      col_oh_q      <= col_oh_d;
      dwell_q       <= dwell_d;
      deb_q         <= deb_d;
      cand_row_q    <= cand_row_d;
      cand_col_q    <= cand_col_d;
      rep_q         <= rep_d;
      rep_first_q   <= rep_first_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_repeat_q  <= key_repeat_d;
      key_held_q    <= key_held_d;
      key_release_q <= key_release_d;
      multi_key_q   <= multi_key_d;
    end
  end

  assign col_q       = col_oh_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_repeat  = key_repeat_q;
  assign key_held    = key_held_q;
  assign key_release = key_release_q;
  assign multi_key   = multi_key_q;

endmodule

`default_nettype wire
